// File: rtl/sumador_serie_nibbles.sv
// Serial multi-nibble adder: sums two 4*NIBBLES-bit operands one nibble per clock,
// LSB nibble first, reusing a single 4-bit carry-lookahead adder (sumador_adivino).

module sumador_adivino (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [4:0] res
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = 1'b0;
    c[1] = g[0];
    c[2] = g[1] | (p[1] & g[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    res  = {c[4], p ^ c[3:0]};
  end
endmodule

// Handshake: inicio is accepted only in IDLE (including the listo cycle); ocupado is
// high for exactly NIBBLES cycles; listo is a one-cycle pulse while resultado is valid.
module sumador_serie_nibbles #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inicio,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  output logic                 ocupado,
  output logic                 listo,
  output logic [4*NIBBLES:0]   resultado
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {IDLE, SUMA} estado_t;

  estado_t       estado, estado_n;
  logic [IW-1:0] idx, idx_n;
  logic          carry, carry_n;
  logic [W-1:0]  a_q, a_n, b_q, b_n;
  logic [W-1:0]  parcial, parcial_n;
  logic          ocupado_n, listo_n;
  logic [W:0]    resultado_n;

  logic [3:0] nib_a, nib_b, suma_nib;
  logic [4:0] res;
  logic       carry_sig;

  assign nib_a = a_q[4*idx +: 4];
  assign nib_b = b_q[4*idx +: 4];

  sumador_adivino u_adivino (
    .a   (nib_a),
    .b   (nib_b),
    .res (res)
  );

  // The CLA has no carry-in, so the inter-nibble carry is folded in afterwards:
  // it can only ripple out when the nibble sum is already 4'hF.
  assign suma_nib  = res[3:0] + {3'b000, carry};
  assign carry_sig = res[4] | (carry & (&res[3:0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      parcial   <= '0;
      ocupado   <= 1'b0;
      listo     <= 1'b0;
      resultado <= '0;
    end else begin
      estado    <= estado_n;
      idx       <= idx_n;
      carry     <= carry_n;
      a_q       <= a_n;
      b_q       <= b_n;
      parcial   <= parcial_n;
      ocupado   <= ocupado_n;
      listo     <= listo_n;
      resultado <= resultado_n;
    end
  end

  always_comb begin
    estado_n    = estado;
    idx_n       = idx;
    carry_n     = carry;
    a_n         = a_q;
    b_n         = b_q;
    parcial_n   = parcial;
    ocupado_n   = ocupado;
    listo_n     = 1'b0;
    resultado_n = resultado;
    case (estado)
      IDLE: begin
        if (inicio) begin
          estado_n  = SUMA;
          a_n       = op_a;
          b_n       = op_b;
          idx_n     = '0;
          carry_n   = 1'b0;
          ocupado_n = 1'b1;
        end
      end
      SUMA: begin
        parcial_n[4*idx +: 4] = suma_nib;
        carry_n               = carry_sig;
        idx_n                 = idx + IW'(1);
        if (idx == IW'(NIBBLES - 1)) begin
          estado_n    = IDLE;
          ocupado_n   = 1'b0;
          listo_n     = 1'b1;
          resultado_n = {carry_sig, parcial_n};
        end
      end
      default: estado_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sumador_serie_nibbles.sv
// Bench for sumador_serie_nibbles (NIBBLES=4): cycle model built from a+b arithmetic,
// directed literal cases, a mid-sum reset and 200 randomized pairs.
`timescale 1ns/1ps

module tb_sumador_serie_nibbles;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inicio = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         ocupado;
  logic         listo;
  logic [W:0]   resultado;

  int checks = 0;
  int errors = 0;

  // model state
  logic [W:0] exp_q[$];
  int         m_cnt = 0;
  logic       m_ocup = 1'b0;
  logic       m_listo = 1'b0;
  logic [W:0] m_res = '0;
  int         m_accepts = 0;
  int         dut_listos = 0;

  sumador_serie_nibbles #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .inicio    (inicio),
    .op_a      (op_a),
    .op_b      (op_b),
    .ocupado   (ocupado),
    .listo     (listo),
    .resultado (resultado)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Model: an accepted request yields a+b exactly N edges later; requests are
  // seen only when no sum is pending.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt   = 0;
      m_ocup  = 1'b0;
      m_listo = 1'b0;
      m_res   = '0;
      exp_q.delete();
    end else begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_listo = 1'b1;
          m_ocup  = 1'b0;
          m_res   = exp_q.pop_front();
        end
      end else begin
        m_listo = 1'b0;
        if (inicio) begin
          exp_q.push_back({1'b0, op_a} + {1'b0, op_b});
          m_cnt  = N;
          m_ocup = 1'b1;
          m_accepts++;
        end
      end
      #1;
      if (!rst) begin
        check("ocupado", {{W{1'b0}}, ocupado}, {{W{1'b0}}, m_ocup});
        check("listo", {{W{1'b0}}, listo}, {{W{1'b0}}, m_listo});
        check("resultado", resultado, m_res);
        if (listo) dut_listos++;
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_ocupado", {{W{1'b0}}, ocupado}, '0);
    check("rst_listo", {{W{1'b0}}, listo}, '0);
    check("rst_resultado", resultado, '0);
    repeat (cycles) @(negedge clk);
    rst        = 1'b0;
    m_accepts  = 0;
    dut_listos = 0;
  endtask

  // One pulse of inicio, then wait (bounded) for listo and pin latency and value.
  task automatic do_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] req);
    int cnt;
    @(negedge clk);
    inicio = 1'b1;
    op_a   = a;
    op_b   = b;
    @(negedge clk);
    inicio = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    cnt    = 1;
    while (!listo && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", (W+1)'(cnt - 1), (W+1)'(N));
    check("lit_result", resultado, req);
    @(negedge clk);
    check("listo_pulse", {{W{1'b0}}, listo}, '0);
  endtask

  initial begin
    int cnt;
    logic [W-1:0] ra, rb;
    #100;
    check("reset_ocupado", {{W{1'b0}}, ocupado}, '0);
    check("reset_listo", {{W{1'b0}}, listo}, '0);
    check("reset_resultado", resultado, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    do_sum(16'h1234, 16'h4321, 17'h05555);
    do_sum(16'h00FF, 16'h0001, 17'h00100);
    do_sum(16'hFFFF, 16'h0001, 17'h10000);
    do_sum(16'hFFFF, 16'hFFFF, 17'h1FFFE);
    do_sum(16'h8000, 16'h8000, 17'h10000);

    // inicio held high with operands changing every cycle
    @(negedge clk);
    inicio = 1'b1;
    op_a   = 16'h0101;
    op_b   = 16'h0202;
    cnt    = 0;
    while (!listo && cnt < 20) begin
      @(negedge clk);
      op_a = $urandom;
      op_b = $urandom;
      cnt++;
    end
    check("held_first", resultado, 17'h00303);
    @(negedge clk);
    check("held_reaccept", {{W{1'b0}}, ocupado}, {{W{1'b0}}, 1'b1});
    repeat (3 * (N + 1)) begin
      op_a = $urandom;
      op_b = $urandom;
      @(negedge clk);
    end
    inicio = 1'b0;
    repeat (N + 2) @(negedge clk);

    // reset two cycles into a sum aborts it
    inicio = 1'b1;
    op_a   = 16'h1111;
    op_b   = 16'h1111;
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);
    do_reset(2);
    cnt = 0;
    repeat (N + 4) begin
      @(negedge clk);
      if (listo) cnt++;
    end
    check("no_listo_after_abort", (W+1)'(cnt), '0);
    do_sum(16'h0003, 16'h0004, 17'h00007);

    // randomized pairs, including requests while busy that must be ignored
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
      if ($urandom_range(0, 7) == 0) rb = W'(16'hFFFF - ra + $urandom_range(0, 1));
      @(negedge clk);
      inicio = 1'b1;
      op_a   = ra;
      op_b   = rb;
      repeat ($urandom_range(1, N + 2)) begin
        @(negedge clk);
        inicio = ($urandom_range(0, 3) == 0);
        op_a   = $urandom;
        op_b   = $urandom;
      end
      inicio = 1'b0;
    end
    repeat (N + 3) @(negedge clk);
    check("listo_count", (W+1)'(dut_listos), (W+1)'(m_accepts));
    check("queue_drained", (W+1)'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not finish, errors %0d", errors);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
